// File: rtl/ibuf_pkg.sv
// rtl/ibuf_pkg.sv - shared sizing constants and helpers for the multi-lane instruction buffer
package ibuf_pkg;

  localparam int unsigned IBUF_DW     = 130;
  localparam int unsigned IBUF_DEPTH  = 8;
  localparam int unsigned IBUF_PUSH_W = 2;
  localparam int unsigned IBUF_POP_W  = 2;

  // Pointer width for a power-of-two depth; a depth of 1 still needs one bit.
  function automatic int unsigned ibuf_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned ibuf_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ibuf_mp_ram.sv
// rtl/ibuf_mp_ram.sv - DEPTH x DW register array, PUSH_W write lanes and POP_W read lanes
// Lane k addresses base + k modulo DEPTH, so multi-lane accesses wrap seamlessly.
module ibuf_mp_ram
  import ibuf_pkg::*;
#(
  parameter int unsigned DW     = IBUF_DW,
  parameter int unsigned DEPTH  = IBUF_DEPTH,
  parameter int unsigned PUSH_W = IBUF_PUSH_W,
  parameter int unsigned POP_W  = IBUF_POP_W,
  parameter int unsigned AW     = ibuf_ptr_w(DEPTH)
) (
  input  logic                clk,
  input  logic [PUSH_W-1:0]   wr_en,
  input  logic [AW-1:0]       wr_base,
  input  logic [PUSH_W*DW-1:0] wr_data,
  input  logic [AW-1:0]       rd_base,
  output logic [POP_W*DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < PUSH_W; k++) begin
      if (wr_en[k]) begin
        mem_d[wr_base + AW'(k)] = wr_data[k*DW +: DW];
      end
    end
  end

  // Storage is intentionally left unreset; only valid lanes are ever consumed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < POP_W; k++) begin
      rd_data[k*DW +: DW] = mem_q[rd_base + AW'(k)];
    end
  end

endmodule

// File: rtl/ibuffer_mp.sv
// rtl/ibuffer_mp.sv - multi-lane fetch-to-decode instruction buffer with single-cycle flush
// Optional occupancy_o port when IBUFFER_MP_OCCUPANCY_EN is defined.
module ibuffer_mp
  import ibuf_pkg::*;
#(
  parameter int unsigned DW     = IBUF_DW,
  parameter int unsigned DEPTH  = IBUF_DEPTH,
  parameter int unsigned PUSH_W = IBUF_PUSH_W,
  parameter int unsigned POP_W  = IBUF_POP_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_flush,
  input  logic [PUSH_W*DW-1:0]        data_i,
  input  logic [PUSH_W-1:0]           valid_i,
  output logic [PUSH_W-1:0]           ready_o,
  output logic [POP_W*DW-1:0]         data_o,
  output logic [POP_W-1:0]            valid_o,
  input  logic [POP_W-1:0]            ready_i
`ifdef IBUFFER_MP_OCCUPANCY_EN
  ,
  output logic [ibuf_cnt_w(DEPTH)-1:0] occupancy_o
`endif
);

  localparam int unsigned AW = ibuf_ptr_w(DEPTH);
  localparam int unsigned CW = ibuf_cnt_w(DEPTH);

  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     free_slots;
  logic [CW-1:0]     n_push, n_pop;
  logic [PUSH_W-1:0] push_acc;
  logic [POP_W-1:0]  pop_acc;
  logic [PUSH_W-1:0] wr_en;

  // Handshake qualifiers depend on registered count only, never on same-cycle pops.
  always_comb begin
    free_slots = CW'(DEPTH) - count_q;
    ready_o    = '0;
    push_acc   = '0;
    n_push     = '0;
    for (int k = 0; k < PUSH_W; k++) begin
      ready_o[k]  = (free_slots >= CW'(k + 1));
      push_acc[k] = valid_i[k] & ready_o[k];
      n_push      = n_push + {{(CW-1){1'b0}}, push_acc[k]};
    end
  end

  always_comb begin
    valid_o = '0;
    pop_acc = '0;
    n_pop   = '0;
    for (int k = 0; k < POP_W; k++) begin
      valid_o[k] = (count_q >= CW'(k + 1));
      pop_acc[k] = valid_o[k] & ready_i[k];
      n_pop      = n_pop + {{(CW-1){1'b0}}, pop_acc[k]};
    end
  end

  always_comb begin
    wr_en = push_acc & {PUSH_W{~valid_flush}};
    if (valid_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(n_pop);
      wr_ptr_d = wr_ptr_q + AW'(n_push);
      count_d  = count_q + n_push - n_pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  ibuf_mp_ram #(
    .DW     (DW),
    .DEPTH  (DEPTH),
    .PUSH_W (PUSH_W),
    .POP_W  (POP_W),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_base (wr_ptr_q),
    .wr_data (data_i),
    .rd_base (rd_ptr_q),
    .rd_data (data_o)
  );

`ifdef IBUFFER_MP_OCCUPANCY_EN
  assign occupancy_o = count_q;
`endif

endmodule

// File: doc/ibuffer_mp.md
# ibuffer_mp

Multi-lane instruction buffer between the fetch stage and the decode stage of the scalar core. It is the multi-issue successor of the single-lane instruction buffer. Per cycle it accepts up to PUSH_W in-order instruction packets from fetch and presents up to POP_W in-order packets to decode. It supports a single-cycle flush on redirect.

## Interface
- DW, 130: width of one instruction packet.
- DEPTH, 8: number of entries. Must be a power of two and at least max(PUSH_W, POP_W).
- PUSH_W, 2: number of fetch lanes written per cycle.
- POP_W, 2: number of decode lanes read per cycle.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_flush  in  1  discards all buffered and incoming packets this cycle.
- data_i  in  PUSH_W*DW  packets; lane k occupies bits [k*DW +: DW].
- valid_i  in  PUSH_W  per-lane valid. Must be a contiguous prefix (lane k valid implies every lane below k is valid).
- ready_o  out  PUSH_W  bit k = 1 when free entries ≥ k+1.
- data_o  out  POP_W*DW  the oldest POP_W entries; lane 0 is the oldest.
- valid_o  out  POP_W  bit k = 1 when occupancy ≥ k+1.
- ready_i  in  POP_W  per-lane consume. Must be a contiguous prefix.

## Operation
- State:
  - storage array of DEPTH×DW;
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - count, $clog2(DEPTH+1) bits.
- Push: lane k is accepted when valid_i[k] & ready_o[k].
  - n_push is the number of accepted lanes.
  - Lane k is written to storage[wr_ptr+k], and wr_ptr advances by n_push.
- Pop: lane k is consumed when valid_o[k] & ready_i[k].
  - n_pop is the number of consumed lanes.
  - rd_ptr advances by n_pop.
- Count update: count_next = count + n_push − n_pop.
- Non-prefix valid_i or ready_i is illegal. The bench asserts on it; the RTL behaviour is undefined.
- ready_o is computed from the registered count only. Slots freed by pops in the same cycle are not reusable until the next cycle, so there is no combinational path from ready_i to ready_o.
- data_o lane k = storage[rd_ptr+k], read combinationally from registers. Lanes with valid_o low carry don't-care values.
- Flush has priority over push and pop. On the next edge rd_ptr, wr_ptr and count are cleared to 0. Pushes and pops in the flush cycle are discarded. valid_o is not gated in the flush cycle, so decode must ignore its outputs while flushing.
- Wrap-around: lane index arithmetic is performed modulo DEPTH. A multi-lane write or read that straddles the end of storage is legal and must be seamless.

## Timing
- Reset values:
  - valid_o = 0;
  - ready_o = all ones (DEPTH ≥ PUSH_W);
  - count, rd_ptr and wr_ptr = 0;
  - storage is not reset, so data_o is unspecified until its lane is valid.
- Latency: a packet pushed at edge N is visible on valid_o/data_o after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Full (count = DEPTH): ready_o = 0. A simultaneous pop frees space for cycle N+1 only.
- Empty (count = 0): valid_o = 0, and a simultaneous push is not visible until the next cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight packets are lost.

## Configuration
- IBUFFER_MP_OCCUPANCY_EN defined: adds the output occupancy_o, width $clog2(DEPTH+1), driven directly from count (reset 0). Fetch uses it for throttling and performance counters.
- Macro undefined: the port is absent. Behaviour is otherwise identical.

## Structure
- Shared package ibuf_pkg holds:
  - the default packet-width constant (130);
  - the lane-count defaults;
  - a pointer/count width helper function, used by fetch and decode for consistent sizing.
- Sub-module ibuf_mp_ram: DEPTH×DW register array with PUSH_W indexed write ports and POP_W indexed read ports. It takes base pointer plus lane offset and handles wrap internally.
- The top level holds only pointers, count, the handshake logic and flush.

## Test plan
- Reset: rst_n low mid-stream -> valid_o=00 and ready_o=11 immediately; after release, pushing A,B on both lanes -> next cycle valid_o=11 and data_o={B,A} with A on lane 0.
- Fill to full: push 2/cycle with ready_i=00 for 4 cycles (DEPTH=8) -> count=8 and ready_o=00; a further push with valid_i=11 is dropped.
- Full plus simultaneous traffic: at count=8, ready_i=11 and valid_i=11 -> pop 2, push 0 that cycle; next cycle ready_o=11.
- Wrap: pre-load so rd_ptr=7 and count=1, then push 2 -> entries land at indices 0 and 1; pop ordering is preserved across the boundary for 20 random-mix cycles against a reference queue.
- Partial lanes: count=1 with ready_i=11 -> valid_o=01, exactly one pop, count=0; valid_i=01 pushes one packet only.
- Flush: count=5 with valid_flush and valid_i=11 in the same cycle -> next cycle count=0, valid_o=00, and the incoming packets are not stored.
